// File: rtl/ringbuf_pkg.sv
// ringbuf_pkg: register map, bit indices, AXI response codes, FSM states and
// the byte-swap helper shared by the ring-buffer bridge.
package ringbuf_pkg;
  localparam logic [63:0] REG_CTRL   = 64'h00;
  localparam logic [63:0] REG_STATUS = 64'h08;
  localparam logic [63:0] REG_WPTR   = 64'h10;
  localparam logic [63:0] REG_RPTR   = 64'h18;
  localparam logic [63:0] REG_THRESH = 64'h20;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_DROP = 2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_LAST  = 3;
  localparam int ST_RERR  = 4;
  localparam int ST_LVL   = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic {R_IDLE, R_BUSY} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_e;
  // Reverses the low nb bytes of d; bytes above nb come back as zero.
  function automatic logic [255:0] bswap(input logic [255:0] d, input int nb);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*(nb-1-i) +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ringbuf_sdp_ram.sv
// ringbuf_sdp_ram: simple dual-port RAM with one write port and one
// synchronous read port of one-cycle latency.
module ringbuf_sdp_ram #(
  parameter int DW = 256,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/axi_ringbuf_bridge.sv
// axi_ringbuf_bridge: AXI4-MM slave exposing a stream-fed ring buffer and its registers.
// Define RINGBUF_IRQ_EN to implement IRQ_THRESH and the level interrupt o_irq.
module axi_ringbuf_bridge
  import ringbuf_pkg::*;
#(
  parameter int          AXI_IDWIDTH = 4,
  parameter int          STREAM_DW   = 256,
  parameter int          DEPTH_LOG2  = 12,
  parameter int          BSWAP       = 1,
  parameter logic [63:0] BUF_BASE    = 64'h01000000
) (
  input  logic                   rstn,
  input  logic                   clk,
  output logic                   s_axi_awready,
  input  logic                   s_axi_awvalid,
  input  logic [63:0]            s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic [AXI_IDWIDTH-1:0] s_axi_awid,
  output logic                   s_axi_wready,
  input  logic                   s_axi_wvalid,
  input  logic                   s_axi_wlast,
  input  logic [63:0]            s_axi_wdata,
  input  logic                   s_axi_bready,
  output logic                   s_axi_bvalid,
  output logic [AXI_IDWIDTH-1:0] s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_arready,
  input  logic                   s_axi_arvalid,
  input  logic [63:0]            s_axi_araddr,
  input  logic [7:0]             s_axi_arlen,
  input  logic [AXI_IDWIDTH-1:0] s_axi_arid,
  input  logic                   s_axi_rready,
  output logic                   s_axi_rvalid,
  output logic                   s_axi_rlast,
  output logic [63:0]            s_axi_rdata,
  output logic [AXI_IDWIDTH-1:0] s_axi_rid,
  output logic [1:0]             s_axi_rresp,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [STREAM_DW-1:0]   s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   o_irq
);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EB    = STREAM_DW / 8;
  localparam int EBL   = $clog2(EB);
  localparam int LANES = STREAM_DW / 64;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [AXI_IDWIDTH-1:0] rid_q, rid_d, bid_q, bid_d;
  logic [7:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [63:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [63:0] rd_addr, rd_off, reg_rdata, reg_rdata_q, ctrl_rd, status;
  logic rd_buf, rd_buf_q, rd_adv;
  logic [LW-1:0] lane_q;
  logic [STREAM_DW-1:0] ram_dout, ram_wdata;
  logic [PW-1:0] wptr_q, rptr_q, level, delta;
  logic en_q, drop_q, ovf_q, last_q, rerr_q;
  logic full, empty, accept, push, wbeat, ctrl_wr, rptr_wr, rptr_ok, clr;
  logic [15:0] thresh;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    if (r_state_q == R_IDLE && s_axi_arvalid) begin
      r_state_d = R_BUSY;
      rid_d     = s_axi_arid;
      rcnt_d    = s_axi_arlen;
      raddr_d   = s_axi_araddr;
    end
    if (r_state_q == R_BUSY && s_axi_rready) begin
      rcnt_d    = rcnt_q - 8'd1;
      raddr_d   = raddr_q + 64'd8;
      r_state_d = rcnt_q == 8'd0 ? R_IDLE : R_BUSY;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    if (w_state_q == W_IDLE && s_axi_awvalid) begin
      w_state_d = W_BUSY;
      bid_d     = s_axi_awid;
      wcnt_d    = s_axi_awlen;
      waddr_d   = s_axi_awaddr;
    end
    if (w_state_q == W_BUSY && s_axi_wvalid) begin
      wcnt_d    = wcnt_q - 8'd1;
      waddr_d   = waddr_q + 64'd8;
      w_state_d = (wcnt_q == 8'd0 || s_axi_wlast) ? W_RESP : W_BUSY;
    end
    if (w_state_q == W_RESP && s_axi_bready) w_state_d = W_IDLE;
  end

  // Read address for the next beat feeds the RAM directly so data lines up with rvalid.
  assign rd_addr = r_state_q == R_IDLE ? s_axi_araddr : raddr_q + (s_axi_rready ? 64'd8 : 64'd0);
  assign rd_off  = rd_addr - BUF_BASE;
  assign rd_buf  = rd_addr >= BUF_BASE;
  assign rd_adv  = r_state_q == R_IDLE || s_axi_rready;

  assign empty   = wptr_q == rptr_q;
  assign full    = wptr_q[PW-1] != rptr_q[PW-1] && wptr_q[PW-2:0] == rptr_q[PW-2:0];
  assign level   = wptr_q - rptr_q;
  assign delta   = PW'(s_axi_wdata) - rptr_q;
  assign rptr_ok = delta <= level;
  assign wbeat   = w_state_q == W_BUSY && s_axi_wvalid && waddr_q < BUF_BASE;
  assign ctrl_wr = wbeat && waddr_q == REG_CTRL;
  assign rptr_wr = wbeat && waddr_q == REG_RPTR;
  assign clr     = ctrl_wr && s_axi_wdata[CTRL_CLR];
  assign s_axis_tready = en_q && (!full || drop_q);
  assign accept  = s_axis_tvalid && s_axis_tready;
  assign push    = accept && !full;
  assign ram_wdata = BSWAP != 0 ? STREAM_DW'(bswap(256'(s_axis_tdata), EB)) : s_axis_tdata;

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]   = en_q;
    ctrl_rd[CTRL_DROP] = drop_q;
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf_q;
    status[ST_LAST]  = last_q;
    status[ST_RERR]  = rerr_q;
    status[ST_LVL +: 16] = 16'(level);
    reg_rdata = rd_addr == REG_CTRL   ? ctrl_rd
              : rd_addr == REG_STATUS ? status
              : rd_addr == REG_WPTR   ? 64'(wptr_q)
              : rd_addr == REG_RPTR   ? 64'(rptr_q)
              : rd_addr == REG_THRESH ? 64'(thresh) : '0;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state_q   <= R_IDLE;
      w_state_q   <= W_IDLE;
      rid_q       <= '0;
      bid_q       <= '0;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      reg_rdata_q <= '0;
      rd_buf_q    <= 1'b0;
      lane_q      <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      if (rd_adv) begin
        reg_rdata_q <= reg_rdata;
        rd_buf_q    <= rd_buf;
        lane_q      <= LW'((rd_off >> 3) & 64'(LANES - 1));
      end
    end

  // Clear outranks a same-cycle push or RPTR write; RAM contents are left alone.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      en_q   <= 1'b0;
      drop_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      last_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q   <= s_axi_wdata[CTRL_EN];
        drop_q <= s_axi_wdata[CTRL_DROP];
      end
      wptr_q <= clr ? '0 : wptr_q + PW'(push);
      rptr_q <= clr ? '0 : (rptr_wr && rptr_ok) ? PW'(s_axi_wdata) : rptr_q;
      ovf_q  <= !clr && (ovf_q || (accept && full));
      last_q <= !clr && (last_q || (accept && s_axis_tlast));
      rerr_q <= !clr && (rerr_q || (rptr_wr && !rptr_ok));
    end

`ifdef RINGBUF_IRQ_EN
  logic [15:0] thresh_q;
  logic irq_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wbeat && waddr_q == REG_THRESH) thresh_q <= 16'(s_axi_wdata);
      irq_q <= en_q && thresh_q != 16'd0 && 32'(level) >= 32'(thresh_q);
    end
  assign thresh = thresh_q;
  assign o_irq  = irq_q;
`else
  assign thresh = '0;
  assign o_irq  = 1'b0;
`endif

  ringbuf_sdp_ram #(.DW(STREAM_DW), .AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (push && !clr),
    .waddr_i (wptr_q[PW-2:0]),
    .wdata_i (ram_wdata),
    .raddr_i (DEPTH_LOG2'(rd_off >> EBL)),
    .rdata_o (ram_dout)
  );

  assign s_axi_awready = w_state_q == W_IDLE;
  assign s_axi_wready  = w_state_q == W_BUSY;
  assign s_axi_bvalid  = w_state_q == W_RESP;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = r_state_q == R_IDLE;
  assign s_axi_rvalid  = r_state_q == R_BUSY;
  assign s_axi_rlast   = r_state_q == R_BUSY && rcnt_q == 8'd0;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rdata   = r_state_q != R_BUSY ? '0 : rd_buf_q ? ram_dout[lane_q*64 +: 64] : reg_rdata_q;
endmodule

// File: tb/tb_axi_ringbuf_bridge.sv
// tb_axi_ringbuf_bridge: directed scenarios for the ring-buffer bridge with
// a 16-entry, 256-bit, byte-swapping ring.
module tb_axi_ringbuf_bridge;
  localparam int IDW = 4;
  localparam int DW  = 256;
  localparam int DL  = 4;
  localparam logic [63:0] BASE = 64'h01000000;
  localparam logic [63:0] A_CTRL = 64'h00, A_STAT = 64'h08, A_WPTR = 64'h10, A_RPTR = 64'h18, A_THR = 64'h20;

  logic rstn = 1'b0, clk = 1'b0;
  logic awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bready = 0, bvalid;
  logic arready, arvalid = 0, rready = 0, rvalid, rlast, tvalid = 0, tready, tlast = 0, irq;
  logic [63:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [IDW-1:0] awid = 0, bid, arid = 0, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] tdata = 0;
  logic [63:0] rbuf [8];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  axi_ringbuf_bridge #(.AXI_IDWIDTH(IDW), .STREAM_DW(DW), .DEPTH_LOG2(DL), .BSWAP(1), .BUF_BASE(BASE)) dut (
    .rstn(rstn), .clk(clk),
    .s_axi_awready(awready), .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awid(awid),
    .s_axi_wready(wready), .s_axi_wvalid(wvalid), .s_axi_wlast(wlast), .s_axi_wdata(wdata),
    .s_axi_bready(bready), .s_axi_bvalid(bvalid), .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_arready(arready), .s_axi_arvalid(arvalid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arid(arid),
    .s_axi_rready(rready), .s_axi_rvalid(rvalid), .s_axi_rlast(rlast), .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata), .s_axis_tlast(tlast), .o_irq(irq)
  );

  // Stream beat whose most-significant byte is s, then s+1, ... toward the LSB.
  function automatic logic [255:0] pat(input logic [7:0] s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = s + 8'(i);
    return r;
  endfunction

  // After byte reversal, stored byte k equals s+k, so lane l holds s+8l .. s+8l+7.
  function automatic logic [63:0] lane(input logic [7:0] s, input int l);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = s + 8'(8*l + j);
    return r;
  endfunction

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input bit wp = 0, input logic [7:0] ps = 0);
    int n;
    bit to = 0;
    awvalid = 1; awaddr = a; awlen = 0; awid = 4'h3;
    n = 0; while (!awready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) to = 1;
    @(negedge clk); awvalid = 0;
    wvalid = 1; wdata = d; wlast = 1;
    if (wp) begin tvalid = 1; tdata = pat(ps); end
    n = 0; while (!wready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) to = 1;
    @(negedge clk); wvalid = 0; wlast = 0; tvalid = 0;
    bready = 1;
    n = 0; while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (n == 20) to = 1;
    total++;
    if (to || bid !== 4'h3 || bresp !== 2'b00) begin
      bad++; $display("FAIL axi_write addr=%h timeout=%b bid=%h bresp=%h want bid=3 bresp=0", a, to, bid, bresp);
    end
    @(negedge clk); bready = 0;
  endtask

  task automatic axi_read(input logic [63:0] a, input int beats);
    int n;
    bit to = 0;
    arvalid = 1; araddr = a; arlen = 8'(beats - 1); arid = 4'h5;
    n = 0; while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) to = 1;
    @(negedge clk); arvalid = 0; rready = 1;
    for (int b = 0; b < beats; b++) begin
      n = 0; while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (n == 20) to = 1;
      rbuf[b] = rdata;
      total++;
      if (to || rlast !== (b == beats - 1) || rid !== 4'h5 || rresp !== 2'b00) begin
        bad++; $display("FAIL axi_read addr=%h beat=%0d timeout=%b rlast=%b rid=%h rresp=%h", a, b, to, rlast, rid, rresp);
      end
      @(negedge clk);
    end
    rready = 0;
  endtask

  task automatic push(input logic [7:0] s, input logic last = 0);
    int n = 0;
    tvalid = 1; tdata = pat(s); tlast = last;
    while (!tready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; bad++; $display("FAIL push_timeout tready=%b want 1", tready); end
    @(negedge clk); tvalid = 0; tlast = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({awready, arready, wready, bvalid, rvalid, tready, irq} !== 7'b1100000 || rdata !== 64'd0) begin
      bad++; $display("FAIL reset_outputs got=%b rdata=%h want=1100000 rdata=0",
                      {awready, arready, wready, bvalid, rvalid, tready, irq}, rdata);
    end
    rstn = 1;
    @(negedge clk);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h1) begin bad++; $display("FAIL reset_status got=%h want=1", rbuf[0]); end
    axi_read(A_CTRL, 1);
    total++; if (rbuf[0] !== 64'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", rbuf[0]); end
  endtask

  task automatic test_basic;
    axi_write(A_CTRL, 64'h1);
    push(8'h00); push(8'h20); push(8'h40, 1);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_0003_0000_0008) begin bad++; $display("FAIL basic_status got=%h want=0000000300000008", rbuf[0]); end
    axi_read(A_WPTR, 1);
    total++; if (rbuf[0] !== 64'd3) begin bad++; $display("FAIL basic_wptr got=%h want=3", rbuf[0]); end
    axi_read(BASE, 4);
    for (int l = 0; l < 4; l++) begin
      total++;
      if (rbuf[l] !== lane(8'h00, l)) begin bad++; $display("FAIL basic_entry0 lane=%0d got=%h want=%h", l, rbuf[l], lane(8'h00, l)); end
    end
    axi_read(BASE + 64'd48, 1);
    total++; if (rbuf[0] !== lane(8'h20, 2)) begin bad++; $display("FAIL basic_entry1_lane2 got=%h want=%h", rbuf[0], lane(8'h20, 2)); end
    axi_read(A_THR + 64'h8, 1);
    total++; if (rbuf[0] !== 64'd0) begin bad++; $display("FAIL basic_unmapped got=%h want=0", rbuf[0]); end
  endtask

  task automatic test_backpressure;
    axi_write(A_CTRL, 64'h3);
    for (int i = 0; i < 16; i++) push(8'(i));
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL bp_tready_full got=%b want=0", tready); end
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_0010_0000_0002) begin bad++; $display("FAIL bp_status got=%h want=0000001000000002", rbuf[0]); end
    axi_write(A_RPTR, 64'd1);
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL bp_tready_after_rptr got=%b want=1", tready); end
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_000F_0000_0000) begin bad++; $display("FAIL bp_status_after got=%h want=0000000F00000000", rbuf[0]); end
  endtask

  task automatic test_drop;
    push(8'hA0);
    axi_write(A_CTRL, 64'h5);
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL drop_tready got=%b want=1", tready); end
    push(8'hC0);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_0010_0000_0006) begin bad++; $display("FAIL drop_status got=%h want=0000001000000006", rbuf[0]); end
    axi_read(A_WPTR, 1);
    total++; if (rbuf[0] !== 64'd17) begin bad++; $display("FAIL drop_wptr got=%h want=11", rbuf[0]); end
    axi_read(BASE, 1);
    total++; if (rbuf[0] !== lane(8'hA0, 0)) begin bad++; $display("FAIL drop_entry0 got=%h want=%h", rbuf[0], lane(8'hA0, 0)); end
    axi_write(A_CTRL, 64'h7);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h1) begin bad++; $display("FAIL clear_status got=%h want=1", rbuf[0]); end
    axi_read(A_WPTR, 1);
    total++; if (rbuf[0] !== 64'd0) begin bad++; $display("FAIL clear_wptr got=%h want=0", rbuf[0]); end
    axi_read(A_RPTR, 1);
    total++; if (rbuf[0] !== 64'd0) begin bad++; $display("FAIL clear_rptr got=%h want=0", rbuf[0]); end
    axi_read(A_CTRL, 1);
    total++; if (rbuf[0] !== 64'h5) begin bad++; $display("FAIL clear_ctrl got=%h want=5", rbuf[0]); end
  endtask

  task automatic test_wrap;
    int idx = 0;
    int rp = 0;
    axi_write(A_CTRL, 64'h1);
    while (idx <= 32) begin
      for (int k = 0; k < 4; k++) begin push(8'(idx * 3)); idx++; end
      axi_read(A_STAT, 1);
      total++; if (rbuf[0] !== 64'h0000_0004_0000_0000) begin bad++; $display("FAIL wrap_level idx=%0d got=%h want=0000000400000000", idx, rbuf[0]); end
      rp += 4;
      axi_write(A_RPTR, 64'(rp % 32));
    end
    axi_read(A_WPTR, 1);
    total++; if (rbuf[0] !== 64'd4) begin bad++; $display("FAIL wrap_wptr got=%h want=4", rbuf[0]); end
    axi_read(BASE, 4);
    total++; if (rbuf[0] !== lane(8'd96, 0)) begin bad++; $display("FAIL wrap_entry0_l0 got=%h want=%h", rbuf[0], lane(8'd96, 0)); end
    total++; if (rbuf[3] !== lane(8'd96, 3)) begin bad++; $display("FAIL wrap_entry0_l3 got=%h want=%h", rbuf[3], lane(8'd96, 3)); end
  endtask

  task automatic test_bad_rptr;
    for (int i = 0; i < 5; i++) push(8'(i));
    axi_write(A_RPTR, 64'd10);
    axi_read(A_RPTR, 1);
    total++; if (rbuf[0] !== 64'd4) begin bad++; $display("FAIL badrptr_rptr got=%h want=4", rbuf[0]); end
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_0005_0000_0010) begin bad++; $display("FAIL badrptr_status got=%h want=0000000500000010", rbuf[0]); end
    axi_write(A_RPTR, 64'd6, 1, 8'h55);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h0000_0004_0000_0010) begin bad++; $display("FAIL samecycle_status got=%h want=0000000400000010", rbuf[0]); end
    axi_read(A_WPTR, 1);
    total++; if (rbuf[0] !== 64'd10) begin bad++; $display("FAIL samecycle_wptr got=%h want=a", rbuf[0]); end
    axi_write(A_RPTR, 64'd10);
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h11) begin bad++; $display("FAIL rptr_eq_level got=%h want=11", rbuf[0]); end
  endtask

  task automatic test_irq;
    axi_write(A_CTRL, 64'h3);
    axi_write(A_THR, 64'd8);
`ifdef RINGBUF_IRQ_EN
    axi_read(A_THR, 1);
    total++; if (rbuf[0] !== 64'd8) begin bad++; $display("FAIL irq_thresh got=%h want=8", rbuf[0]); end
    for (int i = 0; i < 7; i++) push(8'(i));
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_level7 got=%b want=0", irq); end
    push(8'h07);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_level8 got=%b want=1", irq); end
    axi_write(A_RPTR, 64'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_rptr got=%b want=0", irq); end
`else
    axi_read(A_THR, 1);
    total++; if (rbuf[0] !== 64'd0) begin bad++; $display("FAIL irq_thresh_off got=%h want=0", rbuf[0]); end
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off got=%b want=0", irq); end
`endif
  endtask

  task automatic test_reset_midburst;
    awvalid = 1; awaddr = A_CTRL; awlen = 8'd3; awid = 4'h1;
    arvalid = 1; araddr = BASE; arlen = 8'd3; arid = 4'h2;
    @(negedge clk); awvalid = 0; arvalid = 0;
    total++; if (wready !== 1'b1 || rvalid !== 1'b1) begin bad++; $display("FAIL midburst_busy wready=%b rvalid=%b want 1 1", wready, rvalid); end
    #2 rstn = 0;
    #1;
    total++;
    if ({awready, arready, wready, rvalid, bvalid} !== 5'b11000) begin
      bad++; $display("FAIL midburst_abort got=%b want=11000", {awready, arready, wready, rvalid, bvalid});
    end
    @(negedge clk); rstn = 1;
    @(negedge clk);
    total++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL midburst_noresp bvalid=%b rvalid=%b want 0 0", bvalid, rvalid); end
    axi_read(A_STAT, 1);
    total++; if (rbuf[0] !== 64'h1) begin bad++; $display("FAIL midburst_status got=%h want=1", rbuf[0]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_drop;
    test_wrap;
    test_bad_rptr;
    test_irq;
    test_reset_midburst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
